// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
package cpu_pkg;

   localparam int IMEM_ADDR_W       = 6;
   localparam int LOADER_WORD_BYTES = 4;

   typedef enum logic [2:0] {
      HDR,
      DATA,
      CSUM,
      DONE,
      ERROR
   } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader (UART receiver or bench driver).
interface imem_loader_if;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] rx_data;

   modport master (output rx_valid, output rx_data, input rx_ready);
   modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles a little-endian 32-bit word from four accepted bytes.
module imem_loader_byte_packer
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic [1:0]  idx,
   output logic [31:0] word_next,
   output logic        word_valid
);

   logic [31:0] shreg;

   // Bytes enter at the top so the first byte ends up in bits [7:0].
   assign word_next  = {byte_in, shreg[31:8]};
   assign word_valid = byte_en && (idx == 2'(LOADER_WORD_BYTES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shreg <= '0;
         idx   <= '0;
      end else if (clear) begin
         idx   <= '0;
      end else if (byte_en) begin
         shreg <= word_next;
         idx   <= idx + 2'd1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: packs a checksummed byte image into instruction memory and
// holds the core in reset until the image is verified.
module imem_loader
   import cpu_pkg::*;
#(
   parameter int ADDR_W = IMEM_ADDR_W
) (
   input  logic                clk,
   input  logic                reset_n,
   imem_loader_if.slave        rx,
   input  logic                load_req,
   output logic                imem_write,
   output logic [ADDR_W-1:0]   imem_write_reg,
   output logic [31:0]         imem_write_data,
   output logic                cpu_reset_n,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [ADDR_W:0]     words_loaded
);

   localparam int unsigned DEPTH   = 2 ** ADDR_W;
   localparam int unsigned MAX_HDR = DEPTH - 1;

   typedef logic [ADDR_W:0] cnt_t;

   loader_state_t state;
   cnt_t          n_words;
   logic [7:0]    checksum;
   logic          accept;
   logic          byte_en;
   logic [1:0]    byte_idx;
   logic [31:0]   word_next;
   logic          word_valid;
   cnt_t          words_inc;

   assign rx.rx_ready = (state == HDR) || (state == DATA) || (state == CSUM);
   assign busy        = rx.rx_ready;
   assign accept      = rx.rx_valid && rx.rx_ready;
   assign byte_en     = accept && (state == DATA);
   assign words_inc   = words_loaded + cnt_t'(1);

   imem_loader_byte_packer u_packer (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (state == HDR),
      .byte_en    (byte_en),
      .byte_in    (rx.rx_data),
      .idx        (byte_idx),
      .word_next  (word_next),
      .word_valid (word_valid)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= HDR;
         n_words         <= '0;
         checksum        <= '0;
         words_loaded    <= '0;
         imem_write      <= 1'b0;
         imem_write_reg  <= '0;
         imem_write_data <= '0;
         cpu_reset_n     <= 1'b0;
         done            <= 1'b0;
         error           <= 1'b0;
      end else begin
         imem_write <= 1'b0;
         unique case (state)
            HDR: if (accept) begin
               if (32'(rx.rx_data) > MAX_HDR) begin
                  state <= ERROR;
                  error <= 1'b1;
               end else begin
                  n_words      <= cnt_t'(rx.rx_data) + cnt_t'(1);
                  words_loaded <= '0;
                  checksum     <= '0;
                  state        <= DATA;
               end
            end
            DATA: if (accept) begin
               checksum <= checksum ^ rx.rx_data;
               // Write strobe and counter advance share the edge that takes the 4th byte.
               if (word_valid) begin
                  imem_write      <= 1'b1;
                  imem_write_reg  <= words_loaded[ADDR_W-1:0];
                  imem_write_data <= word_next;
                  words_loaded    <= words_inc;
                  if (words_inc == n_words) state <= CSUM;
               end
            end
            CSUM: if (accept) begin
               if (rx.rx_data == checksum) begin
                  state       <= DONE;
                  done        <= 1'b1;
                  cpu_reset_n <= 1'b1;
               end else begin
                  state <= ERROR;
                  error <= 1'b1;
               end
            end
            DONE, ERROR: if (load_req) begin
               state        <= HDR;
               done         <= 1'b0;
               error        <= 1'b0;
               words_loaded <= '0;
               checksum     <= '0;
               cpu_reset_n  <= 1'b0;
            end
            default: state <= HDR;
         endcase
      end
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time loader directly upstream of instr_memory and cpu_core.
- Accepts a byte stream over a valid/ready handshake, fed by a UART receiver or bench driver.
- Packs the bytes into 32-bit little-endian words and writes them sequentially into instruction memory from word 0.
- Holds the core in reset until a complete, checksum-verified image is loaded.

Parameters:
- ADDR_W, 6, instruction memory word-address width; DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- rx_valid  in  1  byte available on rx_data
- rx_ready  out  1  loader accepts byte; transfer when rx_valid && rx_ready at clk rise
- rx_data  in  8  stream byte
- load_req  in  1  request reload; honoured only in DONE or ERROR
- imem_write  out  1  one-cycle instruction memory write strobe
- imem_write_reg  out  ADDR_W  word address for write
- imem_write_data  out  32  word to write
- cpu_reset_n  out  1  active-low reset to cpu_core; 1 only in DONE
- busy  out  1  high in HDR, DATA, CSUM
- done  out  1  image loaded and verified
- error  out  1  header or checksum failure
- words_loaded  out  ADDR_W+1  count of words written in current load

Behaviour:
- Reset is asynchronous and active-low on reset_n; one clock, clk.
- Reset values: state=HDR, cpu_reset_n=0, imem_write=0, imem_write_reg=0, imem_write_data=0, done=0, error=0, words_loaded=0, checksum=0.
- Stream format:
  - header byte H: word count N = H+1
  - then 4*N data bytes, little-endian per word (byte k goes to bits [8k+7:8k])
  - then one checksum byte equal to the XOR of all data bytes; the header is excluded.
- rx_ready is combinational: 1 in HDR/DATA/CSUM, 0 in DONE/ERROR.
- State HDR, on accepted byte:
  - If H > DEPTH-1, go to ERROR.
  - Else latch N, clear byte index, words_loaded and checksum, and go to DATA.
- State DATA, on accepted byte:
  - Place the byte into the word shift register and XOR it into checksum.
  - Byte index increments mod 4.
  - On the 4th byte of a word, the next cycle drives imem_write=1 with imem_write_reg=words_loaded (pre-increment) and the assembled word. words_loaded increments on the same edge that raises imem_write.
  - imem_write is a single-cycle pulse. rx_ready stays 1 during the pulse, and a new byte may be accepted that cycle.
  - After the 4th byte of word N-1, go to CSUM.
- State CSUM, on accepted byte:
  - Match: go to DONE, set done=1 and cpu_reset_n=1 on that edge.
  - Mismatch: go to ERROR, set error=1; cpu_reset_n stays 0.
- DONE/ERROR with load_req=1: next edge goes to HDR, clears done, error, words_loaded and checksum, and sets cpu_reset_n=0. load_req is ignored in HDR/DATA/CSUM.
- Gaps: rx_valid may drop for any number of cycles in any receive state; no timeout.
- Throughput: one byte per cycle sustained. Latency is 1 cycle from the 4th byte accepted to imem_write.
- Reset mid-load: all state clears asynchronously and the core is held in reset. Memory words already written are left as-is; a new load overwrites them.
- N = DEPTH fills memory exactly; words_loaded reaches DEPTH, hence ADDR_W+1 bits.
- No partial words: the byte index is 0 whenever CSUM is entered.

Decomposition:
- Shared package cpu_pkg holds:
  - IMEM_ADDR_W = 6
  - typedef enum loader_state_t {HDR, DATA, CSUM, DONE, ERROR}
  - LOADER_WORD_BYTES = 4
- Optional sub-module byte_packer handles the 4-byte to 32-bit little-endian assembly, plus the byte index and a word_valid pulse. The FSM, checksum and counters stay in imem_loader.

Test Plan:
- Normal load, two words:
  - Stimulus: stream 0x01, 0x13,0x05,0x10,0x00, 0x93,0x05,0x20,0x00, 0xB0.
  - Response: writes 0x00100513 to word 0 and 0x00200593 to word 1, one imem_write pulse each. Then done=1, cpu_reset_n=1, words_loaded=2; instr_memory contents are verified afterwards.
- Bad checksum: same stream with final byte 0xB1 -> error=1, done=0, cpu_reset_n stays 0, rx_ready=0.
- Oversize header with ADDR_W=6: header 0x40 -> ERROR on the next edge, no imem_write ever asserted.
- Backpressure gaps: the stream from the normal-load case with rx_valid randomly low (1-5 cycle gaps) -> identical writes and final state to the normal load.
- Reset mid-load: assert reset_n=0 after 6 data bytes -> all outputs at reset values immediately. Then a full valid 1-word load (0x00, 0xEF,0xBE,0xAD,0xDE, 0x22) -> word 0 = 0xDEADBEEF, done=1.
- Reload: from DONE, pulse load_req -> cpu_reset_n=0, done=0, busy=1 next cycle. A subsequent valid load completes; load_req pulsed during DATA has no effect.
